// File: rtl/kij_sequencer.sv
// rtl/kij_sequencer.sv - per-kij instruction sequencer driving core's 47-bit inst bus
// Walks one convolution tile: for every kernel offset kij it issues weight SRAM
// reads into the IFIFO, the PE kernel load, activation SRAM reads into L0, the
// execute window and the OFIFO drain into psum SRAM.
// Ports:
//   clk_i          in   clock, all state on rising edge
//   reset_i        in   asynchronous active-high reset
//   start_i        in   begin a tile (sampled in IDLE only)
//   ofifo_valid_i  in   core OFIFO holds a readable row
//   inst_o[46:0]   out  registered instruction word
//   kij_o[3:0]     out  kernel offset currently processed
//   busy_o         out  high outside IDLE
//   done_o         out  one-cycle pulse in the final state
// Optional feature: define KIJ_SEQ_ACC_EN to add the ACC walk over psum SRAM.
// inst bit map: 46 CEN_xmem, 45 WEN_xmem, 44:34 A_xmem, 33 acc, 32 CEN_pmem,
//   31 WEN_pmem, 30:20 A_pmem, 19 CEN_wmem, 18 WEN_wmem, 17:7 A_wmem,
//   6 ofifo_rd, 5 ififo_wr, 4 ififo_rd, 3 l0_rd, 2 l0_wr, 1 execute, 0 load
module kij_sequencer #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_nij = 36,
  parameter int len_kij = 9,
  parameter int in_w    = 6,
  parameter int out_w   = 4,
  parameter int k_w     = 3,
  parameter int gap     = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        ofifo_valid_i,
  output logic [46:0] inst_o,
  output logic [3:0]  kij_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_W_RD, S_W_LOAD, S_GAP, S_X_RD, S_EXEC, S_OF_RD, S_ACC, S_FIN
  } state_e;

  localparam logic [46:0] INST_IDLE = (47'd1 << 46) | (47'd1 << 45) | (47'd1 << 32) |
                                      (47'd1 << 31) | (47'd1 << 19) | (47'd1 << 18);

  localparam logic [7:0] W_RD_LAST   = 8'(col);
  localparam logic [7:0] W_LOAD_LAST = 8'(row + 2 * col - 1);
  localparam logic [7:0] GAP_LAST    = 8'(gap - 1);
  localparam logic [7:0] X_RD_LAST   = 8'(len_nij);
  localparam logic [7:0] EXEC_LAST   = 8'(len_nij + row + col - 1);
  localparam logic [7:0] NIJ         = 8'(len_nij);
  localparam logic [7:0] KIJ_N       = 8'(len_kij);
  localparam logic [3:0] KIJ_LAST    = 4'(len_kij - 1);
  // ACC group: clear slot, len_kij reads, acc tail slot, idle slot
  localparam logic [7:0] ACC_LAST    = 8'(len_kij + 2);
  localparam logic [7:0] O_LAST      = 8'(out_w * out_w - 1);

  localparam logic [31:0] COL_W = 32'(col);
  localparam logic [31:0] NIJ_W = 32'(len_nij);
  localparam logic [31:0] IN_W  = 32'(in_w);
  localparam logic [31:0] OUT_W = 32'(out_w);
  localparam logic [31:0] K_W   = 32'(k_w);

  state_e      state_q, state_d;
  logic [7:0]  t_q, t_d;
  logic [7:0]  p_q, p_d;     // OF_RD read index, or output pixel o in ACC
  logic        rd_q, rd_d;   // current OF_RD cycle carries a read
  logic [3:0]  kij_q, kij_d;
  logic [46:0] inst_q, inst_d;
  logic [7:0]  p_next;

  logic [31:0] k_acc, o_acc;
  logic [10:0] a_w, a_x, a_p, a_acc;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      p_q     <= '0;
      rd_q    <= 1'b0;
      kij_q   <= '0;
      inst_q  <= INST_IDLE;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      p_q     <= p_d;
      rd_q    <= rd_d;
      kij_q   <= kij_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q + 8'd1;
    p_d     = p_q;
    rd_d    = 1'b0;
    kij_d   = kij_q;
    p_next  = p_q + {7'd0, rd_q};
    case (state_q)
      S_IDLE: begin
        t_d = '0;
        p_d = '0;
        if (start_i) state_d = S_W_RD;
      end
      S_W_RD:   if (t_q == W_RD_LAST)   begin state_d = S_W_LOAD; t_d = '0; end
      S_W_LOAD: if (t_q == W_LOAD_LAST) begin state_d = S_GAP;    t_d = '0; end
      S_GAP:    if (t_q == GAP_LAST)    begin state_d = S_X_RD;   t_d = '0; end
      S_X_RD:   if (t_q == X_RD_LAST)   begin state_d = S_EXEC;   t_d = '0; end
      S_EXEC: begin
        if (t_q == EXEC_LAST) begin
          state_d = S_OF_RD;
          t_d     = '0;
          p_d     = '0;
          rd_d    = ofifo_valid_i;
        end
      end
      S_OF_RD: begin
        t_d = t_q;
        // the read presented this cycle counts before deciding to leave
        if (p_next == NIJ) begin
          t_d = '0;
          p_d = '0;
          if (kij_q == KIJ_LAST) begin
`ifdef KIJ_SEQ_ACC_EN
            state_d = S_ACC;
`else
            state_d = S_FIN;
`endif
          end else begin
            kij_d   = kij_q + 4'd1;
            state_d = S_W_RD;
          end
        end else begin
          p_d  = p_next;
          rd_d = ofifo_valid_i;
        end
      end
      S_ACC: begin
        if (t_q == ACC_LAST) begin
          t_d = '0;
          if (p_q == O_LAST) begin
            state_d = S_FIN;
            p_d     = '0;
          end else begin
            p_d = p_q + 8'd1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        kij_d   = '0;
        t_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // inst is built from the next-cycle values so it lands with the state entry
  always_comb begin
    inst_d = INST_IDLE;
    k_acc  = {24'd0, t_d} - 32'd1;
    o_acc  = {24'd0, p_d};
    a_w    = 11'({28'd0, kij_d} * COL_W + {24'd0, t_d});
    a_x    = 11'({24'd0, t_d});
    a_p    = 11'({28'd0, kij_d} * NIJ_W + {24'd0, p_d});
    a_acc  = 11'(k_acc * NIJ_W + (o_acc / OUT_W + k_acc / K_W) * IN_W +
                 (o_acc % OUT_W + k_acc % K_W));
    case (state_d)
      S_W_RD: begin
        if (t_d < W_RD_LAST) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = a_w;
        end
        if (t_d != 8'd0) inst_d[5] = 1'b1;
      end
      S_W_LOAD: begin
        inst_d[4] = 1'b1;
        inst_d[0] = 1'b1;
      end
      S_X_RD: begin
        if (t_d < NIJ) begin
          inst_d[46]    = 1'b0;
          inst_d[44:34] = a_x;
        end
        if (t_d != 8'd0) inst_d[2] = 1'b1;
      end
      S_EXEC: begin
        inst_d[3] = 1'b1;
        inst_d[1] = 1'b1;
      end
      S_OF_RD: begin
        if (rd_d) begin
          inst_d[6]     = 1'b1;
          inst_d[32]    = 1'b0;
          inst_d[31]    = 1'b0;
          inst_d[30:20] = a_p;
        end
      end
      S_ACC: begin
        if (t_d >= 8'd1 && t_d <= KIJ_N) begin
          inst_d[32]    = 1'b0;
          inst_d[30:20] = a_acc;
        end
`ifdef KIJ_SEQ_ACC_EN
        if (t_d >= 8'd2 && t_d <= KIJ_N + 8'd1) inst_d[33] = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign inst_o = inst_q;
  assign kij_o  = kij_q;
  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_FIN);

endmodule
